qspi_reg_target: RTL and testbench
==================================

# qspi_reg_target

Quad-SPI responder that terminates the chip's 4-bit SPI port (CS_N, SCK, COPI[3:0], CIPO[3:0]) and converts each frame into a single register-bus read or write. It sits between the pads and the configuration register file (chip ID, FIFO reset, IRQ thresholds, DAC configs, biases), entirely in the `clk` domain, oversampling SCK. It is the target-side counterpart of the bench SPI controller's byte/half-word/word read and write transactions.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for CS_N, SCK and COPI.
- `AW`, 8: register byte-address width.
- `clk`  in  1  system clock; must be ≥ 8× SCK frequency (40 MHz clk gives SCK ≤ 5 MHz).
- `rst`  in  1  reset, synchronous and active-high.
- `cs_n`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `sck`  in  1  SPI clock, mode 0, asynchronous to `clk`.
- `copi`  in  4  controller-to-target nibble.
- `cipo`  out  4  target-to-controller nibble.
- `cipo_oe`  out  1  CIPO pad output enable.
- `reg_addr`  out  AW  word-aligned byte address (`[1:0]` = 0).
- `reg_wdata`  out  32  write data, lane-aligned.
- `reg_be`  out  4  byte enables.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  32  read data, valid exactly one `clk` after `reg_re`.

## Operation
- Frame: CS_N falls, then nibbles MSB-first: command (2 nibbles), address (2 nibbles), then write data, or 2 turnaround SCK cycles followed by read data.
- Command byte: `[7]` 1 = read; `[5:4]` size (0 = byte/2 nibbles, 1 = half-word/4, 2 = word/8); all other bits 0. Size 3 or any nonzero reserved bit makes the command invalid.
- COPI is sampled on SCK rising edges. CIPO is updated on SCK falling edges.
- Address alignment: the low address bits below the size are ignored. `reg_addr = {addr[AW-1:2], 2'b00}`.
- Byte enables: byte → `1 << addr[1:0]`; half → `4'b0011 << {addr[1],1'b0}`; word → `4'hF`. Data is shifted into the matching lanes; unused lanes are 0.
- Reads: extract the lanes selected by `reg_be` and shift them out MSB nibble first.
- States:
  - IDLE →(CS_N low) CMD →(2 nibbles) ADDR.
  - ADDR → WDATA, or TURN for reads; invalid command → IGNORE.
  - WDATA →(last nibble) WRITE; pulse `reg_we` for one cycle → IGNORE.
  - TURN: `reg_re` is pulsed on entry and `reg_rdata` is captured the next cycle; after 2 SCK cycles → RDATA.
  - RDATA →(last nibble) IGNORE.
  - IGNORE: holds until CS_N high; further SCK edges have no effect.
  - Any state →(CS_N high, synchronized) IDLE.
- `cipo_oe` = 1 only in TURN and RDATA. `cipo` = 0 whenever `cipo_oe` = 0.
- Abort: CS_N high before the last write nibble means no `reg_we`. CS_N high during a read discards the rest of the read; the `reg_re` already issued is not retracted.
- Extra nibbles after a completed transaction are ignored; there is no auto-increment.
- Reset: state IDLE. `cipo`, `cipo_oe`, `reg_we`, `reg_re`, `reg_be`, `reg_addr`, `reg_wdata` are all 0. Asserting `rst` mid-frame leaves the block in IGNORE until CS_N is seen high, so no partial frame is ever decoded.
- CS_N already low when `rst` is released: enter IGNORE (same rule).

## Timing
- Synchronizer latency: `SYNC_STAGES` clk. Edge detect adds 1 clk.
- SCK rising edge to nibble captured: 3 clk.
- SCK falling edge to new `cipo` valid: ≤ 4 clk. Requires SCK low time ≥ 5 clk.
- Last write nibble's SCK edge to `reg_we`: 4 clk.
- `reg_re` asserts 4 clk after the last address SCK rising edge. `reg_rdata` is sampled at +1 clk. Two turnaround SCK cycles guarantee the data is loaded before the first read nibble's falling edge.
- Strobes are single-cycle, and at most one strobe is issued per frame.
- Minimum CS_N high time between frames: 4 clk.

## Structure
- Package `pkg_qspi`:
  - State enum.
  - Size enum (BT/HW/WD).
  - Command bit positions.
  - Nibble-count constants (2/4/8).
  - Turnaround length 2.
- Sub-module `qspi_sync_edge`: N-flop synchronizer plus rise/fall detect, instantiated for SCK and CS_N. COPI uses the bare synchronizer.
- Top level contains the FSM, nibble counter, shift registers and lane mux.

## Test plan
- READ_BT, addr 0x00, `reg_rdata` = 0x00000055 → `reg_re` pulse with `reg_addr` 0x00 and `reg_be` 4'b0001. CIPO returns 0x5, 0x5.
- WRITE_HW, addr 14 (0x0E), data 0x02AA → one `reg_we`, `reg_addr` 0x0C, `reg_be` 4'b1100, `reg_wdata` 0x02AA0000.
- WRITE_WD, addr 112, data 0x00AAAAAA → `reg_addr` 0x70, `reg_be` 4'hF, `reg_wdata` 0x00AAAAAA. Then READ_WD of the same address with `reg_rdata` 0x00333333 → CIPO sequence 0,0,3,3,3,3,3,3.
- CS_N deasserted after 5 of 8 WRITE_WD data nibbles → no `reg_we`. The next WRITE_BT, addr 1, data 0xF completes normally with `reg_be` 4'b0010 and `reg_wdata` 0x00000F00.
- Invalid command 0x30 (size 3) with 10 further nibbles → no strobes, `cipo_oe` stays 0, block returns to IDLE on CS_N high.
- `rst` pulsed mid-WRITE_HW → all outputs 0 next cycle, no strobe until CS_N toggles high/low. The following READ_HW, addr 20, `reg_rdata` 0x00000100 → CIPO 0,1,0,0.

Source files
------------

// File: rtl/pkg_qspi.sv
// Shared types and constants for the quad-SPI register target.
// Frame layout, command decode fields and lane helpers.
package pkg_qspi;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_WRITE,
        ST_TURN,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BT = 2'd0,
        SZ_HW = 2'd1,
        SZ_WD = 2'd2
    } size_e;

    localparam int CMD_RD_BIT = 7;
    localparam int CMD_SZ_HI  = 5;
    localparam int CMD_SZ_LO  = 4;
    localparam logic [7:0] CMD_RSVD_MASK = 8'h4F;

    localparam logic [3:0] CMD_NIBS    = 4'd2;
    localparam logic [3:0] ADDR_NIBS   = 4'd2;
    localparam logic [3:0] NIB_BT      = 4'd2;
    localparam logic [3:0] NIB_HW      = 4'd4;
    localparam logic [3:0] NIB_WD      = 4'd8;
    localparam logic [3:0] TURN_CYCLES = 4'd2;

    function automatic logic [3:0] size_nibs(input size_e s);
        logic [3:0] n;
        unique case (s)
            SZ_BT:   n = NIB_BT;
            SZ_HW:   n = NIB_HW;
            default: n = NIB_WD;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] be_of(input size_e s, input logic [1:0] off);
        logic [3:0] be;
        unique case (s)
            SZ_BT:   be = 4'b0001 << off;
            SZ_HW:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    // Raw shifted-in data sits in the low bits; move it onto its lanes.
    function automatic logic [31:0] wr_align(input size_e s, input logic [1:0] off,
                                             input logic [31:0] raw);
        logic [31:0] w;
        unique case (s)
            SZ_BT:   w = {24'h0, raw[7:0]} << {off, 3'b000};
            SZ_HW:   w = {16'h0, raw[15:0]} << {off[1], 4'h0};
            default: w = raw;
        endcase
        return w;
    endfunction

    // Selected lanes end up MSB-aligned so they shift out top nibble first.
    function automatic logic [31:0] rd_extract(input size_e s, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] t;
        logic [31:0] r;
        unique case (s)
            SZ_BT: begin
                t = rdata >> {off, 3'b000};
                r = {t[7:0], 24'h0};
            end
            SZ_HW: begin
                t = rdata >> {off[1], 4'h0};
                r = {t[15:0], 16'h0};
            end
            default: begin
                t = rdata;
                r = t;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qspi_sync.sv
// Plain multi-flop synchronizer for asynchronous pad inputs.
// Used directly for the COPI nibble.
module qspi_sync #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] stage_q;
    logic [N-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/qspi_sync_edge.sv
// Synchronizer plus rise/fall detect for SCK and CS_N.
// Edge pulses are valid in the same cycle the synchronized level changes.
module qspi_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    qspi_sync #(
        .N (N),
        .W (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (level)
    );

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/qspi_reg_target.sv
// Quad-SPI responder turning each frame into one register read or write.
// Oversamples SCK in the clk domain; mode 0, MSB nibble first.
module qspi_reg_target
    import pkg_qspi::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs_n,
    input  logic          sck,
    input  logic [3:0]    copi,
    output logic [3:0]    cipo,
    output logic          cipo_oe,
    output logic [AW-1:0] reg_addr,
    output logic [31:0]   reg_wdata,
    output logic [3:0]    reg_be,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [31:0]   reg_rdata
);

    logic       cs_s;
    logic       cs_rise;
    logic       cs_fall;
    logic       sck_s;
    logic       sck_rise;
    logic       sck_fall;
    logic [3:0] copi_s;

    qspi_sync_edge #(.N(SYNC_STAGES)) u_cs (
        .clk   (clk),
        .rst   (rst),
        .d     (cs_n),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    qspi_sync_edge #(.N(SYNC_STAGES)) u_sck (
        .clk   (clk),
        .rst   (rst),
        .d     (sck),
        .level (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    qspi_sync #(.N(SYNC_STAGES), .W(4)) u_copi (
        .clk (clk),
        .rst (rst),
        .d   (copi),
        .q   (copi_s)
    );

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   sh_q, sh_d;
    logic [7:0]    cmd_q, cmd_d;
    size_e         size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          re_pend_q, re_pend_d;
    logic          rd_cap_q, rd_cap_d;
    logic [3:0]    cipo_q, cipo_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;
    logic [3:0]    reg_be_q, reg_be_d;
    logic          reg_we_q, reg_we_d;
    logic          reg_re_q, reg_re_d;

    logic [31:0]   sh_in;
    logic [AW-1:0] addr_full;
    size_e         cmd_sz;
    logic          cmd_ok;
    logic [3:0]    nib_n;

    assign sh_in     = {sh_q[27:0], copi_s};
    assign addr_full = AW'({sh_q[3:0], copi_s});
    assign cmd_sz    = size_e'(cmd_q[CMD_SZ_HI:CMD_SZ_LO]);
    assign cmd_ok    = ((cmd_q & CMD_RSVD_MASK) == 8'h00) &&
                       (cmd_q[CMD_SZ_HI:CMD_SZ_LO] != 2'd3);
    assign nib_n     = size_nibs(size_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        cmd_d       = cmd_q;
        size_d      = size_q;
        off_d       = off_q;
        re_pend_d   = 1'b0;
        rd_cap_d    = reg_re_q;
        cipo_d      = cipo_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_be_d    = reg_be_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                // A frame must open with a clean CS_N fall while SCK idles low.
                if (!cs_s) begin
                    state_d = (cs_fall && !sck_s) ? ST_CMD : ST_IGNORE;
                end
            end
            ST_CMD: begin
                if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == CMD_NIBS - 4'd1) begin
                        cmd_d   = sh_in[7:0];
                        cnt_d   = 4'd0;
                        state_d = ST_ADDR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == ADDR_NIBS - 4'd1) begin
                        cnt_d = 4'd0;
                        if (!cmd_ok) begin
                            state_d = ST_IGNORE;
                        end else begin
                            size_d     = cmd_sz;
                            off_d      = addr_full[1:0];
                            reg_addr_d = {addr_full[AW-1:2], 2'b00};
                            reg_be_d   = be_of(cmd_sz, addr_full[1:0]);
                            sh_d       = '0;
                            if (cmd_q[CMD_RD_BIT]) begin
                                re_pend_d = 1'b1;
                                state_d   = ST_TURN;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_WDATA: begin
                if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == nib_n - 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_WRITE: begin
                reg_we_d    = 1'b1;
                reg_wdata_d = wr_align(size_q, off_q, sh_q);
                state_d     = ST_IGNORE;
            end
            ST_TURN: begin
                reg_re_d = re_pend_q;
                if (rd_cap_q) begin
                    sh_d = rd_extract(size_q, off_q, reg_rdata);
                end
                if (sck_rise) begin
                    if (cnt_q == TURN_CYCLES - 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_RDATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_RDATA: begin
                if (sck_fall && (cnt_q != nib_n)) begin
                    cipo_d = sh_q[31:28];
                    sh_d   = {sh_q[27:0], 4'h0};
                    cnt_d  = cnt_q + 4'd1;
                end else if (sck_rise && (cnt_q == nib_n)) begin
                    cipo_d  = 4'h0;
                    state_d = ST_IGNORE;
                end
            end
            ST_IGNORE: begin
                state_d = ST_IGNORE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cs_rise) begin
            cipo_d = 4'h0;
        end
        if (cs_s) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= '0;
            cmd_q       <= '0;
            size_q      <= SZ_BT;
            off_q       <= 2'd0;
            re_pend_q   <= 1'b0;
            rd_cap_q    <= 1'b0;
            cipo_q      <= 4'h0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_be_q    <= 4'h0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            cmd_q       <= cmd_d;
            size_q      <= size_d;
            off_q       <= off_d;
            re_pend_q   <= re_pend_d;
            rd_cap_q    <= rd_cap_d;
            cipo_q      <= cipo_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_be_q    <= reg_be_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    assign cipo_oe   = (state_q == ST_TURN) || (state_q == ST_RDATA);
    assign cipo      = cipo_oe ? cipo_q : 4'h0;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_be    = reg_be_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;

endmodule

// File: tb/tb_qspi_reg_target.sv
// Scoreboard bench for qspi_reg_target: stimulus queues expected strobes
// and CIPO nibbles, independent monitors pop and compare.
module tb_qspi_reg_target;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [3:0]  copi = 4'h0;
    logic [31:0] reg_rdata = 32'hDEADBEEF;
    logic [3:0]  cipo;
    logic        cipo_oe;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_we;
    logic        reg_re;

    qspi_reg_target #(
        .SYNC_STAGES (2),
        .AW          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sck       (sck),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_WE, EV_RE, EV_NIB} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  nib;
    } ev_t;

    ev_t exp_q[$];
    ev_t se;
    ev_t ne;
    int  n_cmp = 0;
    int  n_bad = 0;

    logic [31:0] rd_val = 32'h0;
    logic        rd_pend = 1'b0;
    logic        rd_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic void push_we(input logic [7:0] a, input logic [3:0] be,
                                    input logic [31:0] wd);
        ev_t e;
        e.kind = EV_WE; e.addr = a; e.be = be; e.wdata = wd; e.nib = 4'h0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_re(input logic [7:0] a, input logic [3:0] be);
        ev_t e;
        e.kind = EV_RE; e.addr = a; e.be = be; e.wdata = 32'h0; e.nib = 4'h0;
        exp_q.push_back(e);
    endfunction

    // Two turnaround zeros, then the hand-listed nibbles MSB first.
    function automatic void push_nibs(input logic [31:0] v, input int n);
        ev_t e;
        e.kind = EV_NIB; e.addr = 8'h0; e.be = 4'h0; e.wdata = 32'h0;
        e.nib = 4'h0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int i = n - 1; i >= 0; i--) begin
            e.nib = v[4*i +: 4];
            exp_q.push_back(e);
        end
    endfunction

    // Register file model: data valid the cycle after reg_re, garbage otherwise.
    always @(negedge clk) begin
        if (rd_hold) begin
            reg_rdata = 32'hDEADBEEF;
            rd_hold = 1'b0;
        end
        if (rd_pend) begin
            reg_rdata = rd_val;
            rd_pend = 1'b0;
            rd_hold = 1'b1;
        end
        if (!rst && reg_re) rd_pend = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && (reg_we || reg_re)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_unexpected: we=%b re=%b addr=%h", reg_we, reg_re, reg_addr);
            end else begin
                se = exp_q.pop_front();
                check("strobe_kind", reg_we ? EV_WE : EV_RE, se.kind);
                check("strobe_addr", reg_addr, se.addr);
                check("strobe_be", reg_be, se.be);
                if (reg_we) check("strobe_wdata", reg_wdata, se.wdata);
            end
        end
    end

    always @(posedge sck) begin
        if (cipo_oe) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cipo_unexpected: cipo_oe=1 cipo=%h", cipo);
            end else begin
                ne = exp_q.pop_front();
                check("cipo_kind", EV_NIB, ne.kind);
                check("cipo_nib", cipo, ne.nib);
            end
        end else begin
            check("cipo_idle", cipo, 32'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic nib(input logic [3:0] v);
        copi = v;
        tick(HALF);
        sck = 1'b1;
        tick(HALF);
        sck = 1'b0;
    endtask

    task automatic start();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic stop();
        tick(2);
        cs_n = 1'b1;
        copi = 4'h0;
        tick(8);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] addr);
        nib(cmd[7:4]);
        nib(cmd[3:0]);
        nib(addr[7:4]);
        nib(addr[3:0]);
    endtask

    task automatic send_data(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) nib(d[4*i +: 4]);
    endtask

    task automatic write_frame(input logic [7:0] cmd, input logic [7:0] addr,
                               input logic [31:0] d, input int n);
        start();
        send_hdr(cmd, addr);
        send_data(d, n);
        stop();
    endtask

    task automatic read_frame(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        start();
        send_hdr(cmd, addr);
        repeat (2 + n) nib(4'h0);
        stop();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cipo"}, cipo, 32'h0);
        check({tag, "_cipo_oe"}, cipo_oe, 32'h0);
        check({tag, "_we"}, reg_we, 32'h0);
        check({tag, "_re"}, reg_re, 32'h0);
        check({tag, "_be"}, reg_be, 32'h0);
        check({tag, "_addr"}, reg_addr, 32'h0);
        check({tag, "_wdata"}, reg_wdata, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        tick(4);
        check_zero("reset");
        rst = 1'b0;
        tick(8);

        rd_val = 32'h00000055;
        push_re(8'h00, 4'b0001);
        push_nibs(32'h55, 2);
        read_frame(8'h80, 8'h00, 2);

        push_we(8'h0C, 4'b1100, 32'h02AA0000);
        write_frame(8'h10, 8'h0E, 32'h02AA, 4);

        push_we(8'h70, 4'hF, 32'h00AAAAAA);
        write_frame(8'h20, 8'h70, 32'h00AAAAAA, 8);

        rd_val = 32'h00333333;
        push_re(8'h70, 4'hF);
        push_nibs(32'h00333333, 8);
        read_frame(8'hA0, 8'h70, 8);

        // Write aborted after 5 of 8 data nibbles: no strobe expected.
        start();
        send_hdr(8'h20, 8'h70);
        send_data(32'h000AAA, 5);
        stop();

        // Byte write with trailing nibbles that must be ignored.
        push_we(8'h00, 4'b0010, 32'h00000F00);
        start();
        send_hdr(8'h00, 8'h01);
        send_data(32'h0F, 2);
        send_data(32'h12, 2);
        stop();

        // Invalid commands: size 3, then reserved bit 6 on a read.
        start();
        send_hdr(8'h30, 8'h44);
        send_data(32'hFFFFFFFF, 8);
        stop();
        start();
        send_hdr(8'hC0, 8'h04);
        send_data(32'h0, 8);
        stop();

        // Reset in the middle of a half-word write.
        start();
        send_hdr(8'h10, 8'h0E);
        send_data(32'h55, 2);
        rst = 1'b1;
        tick(1);
        check_zero("midrst");
        rst = 1'b0;
        send_data(32'h66, 2);
        stop();

        rd_val = 32'h00000100;
        push_re(8'h14, 4'b0011);
        push_nibs(32'h0100, 4);
        read_frame(8'h90, 8'h14, 4);

        rd_val = 32'hA1B2C3D4;
        push_re(8'h04, 4'b1000);
        push_nibs(32'hA1, 2);
        read_frame(8'h80, 8'h07, 2);

        tick(20);
        check("leftover_events", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
